// File: rtl/n_bit_counter_if.sv
// n_bit_counter_if: control and count bus between a counter and its driver
interface n_bit_counter_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic             mode;
   logic             preset;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] out;
   logic             terminal;
   logic             boundary;
   modport master (output enable, mode, preset, load, load_value, input out, terminal, boundary);
   modport slave  (input enable, mode, preset, load, load_value, output out, terminal, boundary);
endinterface

// File: rtl/n_bit_counter.sv
// n_bit_counter: up/down modulo or saturating counter with preset, clamped load
// and a registered pulse on every wrap or blocked saturation step
module n_bit_counter #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] MAX_VALUE    = '1,
   parameter logic [WIDTH-1:0] PRESET_VALUE = MAX_VALUE,
   parameter bit               SATURATE     = 1'b0
) (
   input logic          clk,
   input logic          clear,
   n_bit_counter_if.slave bus
);
   logic [WIDTH-1:0] nxt;
   logic             top, bot, hit;
   assign top          = bus.out == MAX_VALUE;
   assign bot          = bus.out == '0;
   assign hit          = bus.enable && (bus.mode ? bot : top);
   assign bus.terminal = bus.mode ? bot : top;
   assign nxt = bus.preset  ? PRESET_VALUE :
                bus.load    ? (bus.load_value > MAX_VALUE ? MAX_VALUE : bus.load_value) :
                !bus.enable ? bus.out :
                bus.mode    ? (bot ? (SATURATE ? '0 : MAX_VALUE) : bus.out - 1'b1) :
                              (top ? (SATURATE ? MAX_VALUE : '0) : bus.out + 1'b1);
   // a load or preset on a boundary edge overrides the step, so no pulse
   always_ff @(posedge clk) begin
      if (clear) begin
         bus.out      <= '0;
         bus.boundary <= 1'b0;
      end else begin
         bus.out      <= nxt;
         bus.boundary <= hit && !bus.preset && !bus.load;
      end
   end
endmodule

// File: doc/n_bit_counter.md
N_BIT_COUNTER -- requirements
Module: n_bit_counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter width in bits (legal range 2..32).
REQ-002 Parameter MAX_VALUE, default 2**WIDTH-1, SHALL set the top count (modulus MAX_VALUE+1); legal range 1..2**WIDTH-1.
REQ-003 Parameter PRESET_VALUE, default MAX_VALUE, SHALL set the value loaded by preset; it must be <= MAX_VALUE.
REQ-004 Parameter SATURATE, default 0, SHALL select the boundary mode: 0 = wrap around, 1 = hold at the boundary.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port clear, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-007 Port enable, input, 1 bit, SHALL allow counting when high.
REQ-008 Port mode, input, 1 bit, SHALL select the direction: 0 = up, 1 = down.
REQ-009 Port preset, input, 1 bit, SHALL be a synchronous load of PRESET_VALUE.
REQ-010 Port load, input, 1 bit, SHALL be a synchronous load of load_value.
REQ-011 Port load_value, input, WIDTH bits, SHALL be the data for load.
REQ-012 Port out, output, WIDTH bits, SHALL be the registered count.
REQ-013 Port terminal, output, 1 bit, SHALL be combinational: high when (mode=0 and out==MAX_VALUE) or (mode=1 and out==0).
REQ-014 Port boundary, output, 1 bit, SHALL be a registered one-cycle pulse that flags a wrap or a blocked saturation step.

Function
REQ-015 Each rising edge SHALL apply exactly one action, in this priority: clear > preset > load > enable count > hold.
REQ-016 preset SHALL set out=PRESET_VALUE on the next edge, whatever the enable or mode value.
REQ-017 load SHALL set out=load_value on the next edge; if load_value > MAX_VALUE, out SHALL become MAX_VALUE (clamp).
REQ-018 With enable=1, mode=0 and out<MAX_VALUE, out SHALL increment by 1 on each edge.
REQ-019 With enable=1, mode=1 and out>0, out SHALL decrement by 1 on each edge.
REQ-020 Up at MAX_VALUE: SATURATE=0 SHALL set out to 0; SATURATE=1 SHALL hold out at MAX_VALUE.
REQ-021 Down at 0: SATURATE=0 SHALL set out to MAX_VALUE; SATURATE=1 SHALL hold out at 0.
REQ-022 boundary SHALL be 1 for exactly the cycle after any edge where REQ-020 or REQ-021 applied, and 0 otherwise.
REQ-023 boundary SHALL repeat on every enabled edge while the counter stays saturated at its boundary.
REQ-024 With enable=0 and no clear, preset or load, out SHALL hold and boundary SHALL be 0.
REQ-025 mode SHALL be sampled on each edge; a direction change SHALL take effect on that same edge with no dead cycle.
REQ-026 All arithmetic SHALL be WIDTH bits, and out SHALL never exceed MAX_VALUE after any edge.
REQ-027 preset or load asserted on a boundary edge SHALL take priority; boundary SHALL then be 0.

Reset
REQ-028 clear=1 at a rising edge SHALL set out=0 and boundary=0, whatever the other inputs.
REQ-029 clear asserted mid-count SHALL take effect on the next edge.
REQ-030 After clear is released, counting SHALL resume on the first edge where enable=1.
REQ-031 No output SHALL change asynchronously; terminal SHALL follow out and mode combinationally.

Verification
REQ-032 WIDTH=4, MAX_VALUE=9, SATURATE=0, clear then enable=1, mode=0, 12 edges -> out 1..9, 0, 1, 2; boundary pulses once, after the 9->0 edge.
REQ-033 Same configuration, mode=1 from out=0, 3 edges -> out 9, 8, 7; boundary high only after the first edge; terminal=1 while out=0 and mode=1.
REQ-034 SATURATE=1, MAX_VALUE=9, up from out=8, 4 edges -> out 9, 9, 9, 9; boundary=1 after edges 2-4.
REQ-035 load=1 with load_value=14 (MAX_VALUE=9) -> out=9; preset=1 and load=1 together -> out=PRESET_VALUE.
REQ-036 clear=1 together with preset=1, load=1 and enable=1 at out=5 -> out=0, boundary=0 on the next edge.
REQ-037 enable=0 for 5 edges at out=3 with mode toggling -> out stays 3, boundary stays 0.
